hilo_div_ctrl: RTL and testbench
================================

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 Parameter: none; opcode and state encodings come from the shared package (REQ-030).
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 ex_valid_i  in  1  EX-stage instruction valid.
REQ-006 ex_op_i  in  3  decoded HI/LO op: NOP, DIV, DIVU, MULT, MULTU, MTHI, MTLO.
REQ-007 ex_rs_i, ex_rt_i  in  32 each  source operands.
REQ-008 mul_res_i  in  64  combinational product from the EX multiplier.
REQ-009 flush_i  in  1  pipeline flush.
REQ-010 stall_i  in  1  downstream stall; EX instruction is held.
REQ-011 div_start_o, div_annul_o, div_signed_o  out  1 each  divider controls.
REQ-012 div_op1_o, div_op2_o  out  32 each  divider operands, latched.
REQ-013 div_result_i  in  64  {remainder, quotient}; div_ready_i  in  1  result valid.
REQ-014 hi_o, lo_o  out  32 each  architectural HI/LO.
REQ-015 stall_req_o  out  1  stall request to the pipeline controller.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, and RELEASE.
REQ-017 IDLE SHALL go to WAIT on ex_valid_i & (DIV|DIVU) & ~flush_i.
- On that edge: div_start_o<=1, div_signed_o<=(op==DIV), div_op1_o<=ex_rs_i, div_op2_o<=ex_rt_i.
REQ-018 stall_req_o SHALL be combinational.
- stall_req_o = (state==WAIT) | (state==IDLE & ex_valid_i & (DIV|DIVU) & ~flush_i).
REQ-019 WAIT with div_ready_i=1 SHALL commit the result and enter RELEASE on the same edge.
- hi<=div_result_i[63:32], lo<=div_result_i[31:0], div_start_o<=0.
REQ-020 In RELEASE, div_start_o SHALL stay 0 and stall_req_o SHALL be 0.
- Leave RELEASE for IDLE only when stall_i=0.
- ex_* SHALL be ignored in RELEASE, so the retiring DIV is never restarted.
REQ-021 Divide-by-zero SHALL receive no special handling: the divider's returned value is committed unchanged (0 from the divider).
REQ-022 HI/LO writes in IDLE SHALL occur only when ex_valid_i & ~flush_i & ~stall_i:
- MTHI: hi<=ex_rs_i.
- MTLO: lo<=ex_rs_i.
- MULT/MULTU: {hi,lo}<=mul_res_i.
REQ-023 flush_i in any state SHALL produce the following on the same edge:
- next state IDLE;
- div_start_o<=0;
- no HI/LO write, including when div_ready_i is coincident.
REQ-024 div_annul_o SHALL equal flush_i combinationally.
REQ-025 div_ready_i outside WAIT SHALL be ignored.
REQ-026 Only one division SHALL be outstanding; WAIT ignores ex_op_i.

Reset
REQ-027 On rst=0 at a clock edge the block SHALL apply the following, with reset having priority over flush_i:
- state=IDLE;
- hi_o=lo_o=0;
- div_start_o=div_signed_o=0;
- div_op1_o=div_op2_o=0.
REQ-028 Reset in WAIT SHALL abandon the divide without writing HI/LO.

Configuration
REQ-029 With macro HILO_FWD_EN defined, hi_o/lo_o SHALL bypass the value being written this cycle (MTHI/MTLO/MULT/divider commit); without it, hi_o/lo_o SHALL be the registered values only, with one-cycle write-to-read latency.

Structure
REQ-030 Shared package hilo_pkg SHALL hold:
- the 3-bit opcode constants;
- the state encoding;
- the 32-bit zero-word constant.
REQ-031 The block SHALL be one module with no sub-module; the divider is instantiated alongside it by the EX stage.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- DIV rs=-7 (0xFFFFFFF9), rt=2; model returns {0xFFFFFFFF,0xFFFFFFFD} after 34 cycles.
  - Required: div_signed_o=1; stall_req_o high until the ready edge; hi=0xFFFFFFFF, lo=0xFFFFFFFD; one RELEASE cycle with start=0.
- DIVU rs=100, rt=0; model returns 0.
  - Required: hi=lo=0; FSM back in IDLE after RELEASE.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0.
  - Required: hi/lo updated on the respective edges (same cycle if HILO_FWD_EN).
- MULT with mul_res_i=0x00000001_00000002 and stall_i=1 for 3 cycles.
  - Required: no write while stalled; hi=1, lo=2 after release.
- flush_i in WAIT, coincident with div_ready_i=1.
  - Required: div_annul_o=1; no HI/LO change; IDLE next; a new DIV starts the next cycle.
- rst=0 asserted in WAIT with hi=0xAAAAAAAA.
  - Required: hi=lo=0, start=0, IDLE.

Source files
------------

// File: rtl/hilo_div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hilo_pkg -- shared definitions for the HI/LO divide controller.
//   * 3-bit decoded HI/LO opcodes presented by the EX stage
//   * controller state encoding
//   * 32-bit zero word used for reset values
// ---------------------------------------------------------------------------
package hilo_pkg;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_DIV   = 3'd1;
   localparam logic [2:0] OP_DIVU  = 3'd2;
   localparam logic [2:0] OP_MULT  = 3'd3;
   localparam logic [2:0] OP_MULTU = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RELEASE = 2'd2
   } hilo_state_t;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// hilo_div_ctrl_if -- EX-stage instruction bus plus divider control bus.
//   ex_valid_i/ex_op_i/ex_rs_i/ex_rt_i : decoded EX instruction and operands
//   mul_res_i                           : combinational 64-bit product
//   div_start_o/div_annul_o/div_signed_o: divider controls
//   div_op1_o/div_op2_o                 : latched divider operands
//   div_result_i/div_ready_i            : {remainder, quotient} and its valid
// Modports: slave = the controller, master = EX stage / divider side.
// ---------------------------------------------------------------------------
interface hilo_div_ctrl_if;

   logic        ex_valid_i;
   logic [2:0]  ex_op_i;
   logic [31:0] ex_rs_i;
   logic [31:0] ex_rt_i;
   logic [63:0] mul_res_i;

   logic        div_start_o;
   logic        div_annul_o;
   logic        div_signed_o;
   logic [31:0] div_op1_o;
   logic [31:0] div_op2_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;

   modport slave (
      input  ex_valid_i, ex_op_i, ex_rs_i, ex_rt_i, mul_res_i,
      input  div_result_i, div_ready_i,
      output div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o
   );

   modport master (
      output ex_valid_i, ex_op_i, ex_rs_i, ex_rt_i, mul_res_i,
      output div_result_i, div_ready_i,
      input  div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o
   );

endinterface

// File: rtl/hilo_div_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_div_ctrl -- owns the architectural HI/LO registers and sequences an
// external multi-cycle divider.
// Ports:
//   clk, rst      : clock (rising edge), synchronous active-low reset
//   bus (slave)   : EX instruction bus and divider control bus
//   flush_i       : pipeline flush, annuls any divide and blocks HI/LO writes
//   stall_i       : downstream stall, EX instruction held
//   hi_o, lo_o    : architectural HI/LO
//   stall_req_o   : stall request while a divide is launching/outstanding
//   state_o       : controller state, for observation
// Optional feature: define HILO_FWD_EN to bypass the value being written this
// cycle onto hi_o/lo_o; otherwise they show registered values only.
//
// Handshake: ex_valid_i qualifies ex_op_i and operands. div_start_o rises on
// the launch edge and stays high until the edge that samples div_ready_i=1
// in WAIT (or a flush/reset); div_ready_i is only accepted in WAIT and
// div_result_i is consumed on that same edge. div_annul_o mirrors flush_i.
// ---------------------------------------------------------------------------
module hilo_div_ctrl
   import hilo_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   hilo_div_ctrl_if.slave bus,
   input  logic           flush_i,
   input  logic           stall_i,
   output logic [31:0]    hi_o,
   output logic [31:0]    lo_o,
   output logic           stall_req_o,
   output hilo_state_t    state_o
);

   hilo_state_t state_q, state_d;

   logic        div_req;
   logic        launch;
   logic        commit;
   logic        hi_we, lo_we;
   logic [31:0] hi_wdata, lo_wdata;

   logic [31:0] hi_q, lo_q;
   logic        div_start_q, div_signed_q;
   logic [31:0] div_op1_q, div_op2_q;

   assign div_req = bus.ex_valid_i & is_div_op(bus.ex_op_i) & ~flush_i;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (div_req)         state_d = ST_WAIT;
            ST_WAIT:    if (bus.div_ready_i) state_d = ST_RELEASE;
            // The retiring divide leaves only once the pipeline moves on.
            ST_RELEASE: if (!stall_i)        state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
         endcase
      end
   end

   // Output / write-enable logic
   always_comb begin
      stall_req_o = 1'b0;
      launch      = 1'b0;
      commit      = 1'b0;
      hi_we       = 1'b0;
      lo_we       = 1'b0;
      hi_wdata    = hi_q;
      lo_wdata    = lo_q;
      case (state_q)
         ST_IDLE: begin
            stall_req_o = div_req;
            launch      = div_req;
            if (bus.ex_valid_i && !flush_i && !stall_i) begin
               case (bus.ex_op_i)
                  OP_MTHI: begin
                     hi_we    = 1'b1;
                     hi_wdata = bus.ex_rs_i;
                  end
                  OP_MTLO: begin
                     lo_we    = 1'b1;
                     lo_wdata = bus.ex_rs_i;
                  end
                  OP_MULT, OP_MULTU: begin
                     hi_we    = 1'b1;
                     lo_we    = 1'b1;
                     hi_wdata = bus.mul_res_i[63:32];
                     lo_wdata = bus.mul_res_i[31:0];
                  end
                  default: ;
               endcase
            end
         end
         ST_WAIT: begin
            stall_req_o = 1'b1;
            // A flush on the ready edge discards the result.
            if (bus.div_ready_i && !flush_i) begin
               commit   = 1'b1;
               hi_we    = 1'b1;
               lo_we    = 1'b1;
               hi_wdata = bus.div_result_i[63:32];
               lo_wdata = bus.div_result_i[31:0];
            end
         end
         default: ;
      endcase
      // Reset wins: nothing is written (or forwarded) while rst is low.
      if (!rst) begin
         hi_we = 1'b0;
         lo_we = 1'b0;
      end
   end

   // HI/LO and divider control registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         hi_q         <= ZERO_WORD;
         lo_q         <= ZERO_WORD;
         div_start_q  <= 1'b0;
         div_signed_q <= 1'b0;
         div_op1_q    <= ZERO_WORD;
         div_op2_q    <= ZERO_WORD;
      end else begin
         if (hi_we) hi_q <= hi_wdata;
         if (lo_we) lo_q <= lo_wdata;
         if (flush_i) begin
            div_start_q <= 1'b0;
         end else if (launch) begin
            div_start_q  <= 1'b1;
            div_signed_q <= (bus.ex_op_i == OP_DIV);
            div_op1_q    <= bus.ex_rs_i;
            div_op2_q    <= bus.ex_rt_i;
         end else if (commit) begin
            div_start_q <= 1'b0;
         end
      end
   end

   assign bus.div_start_o  = div_start_q;
   assign bus.div_signed_o = div_signed_q;
   assign bus.div_op1_o    = div_op1_q;
   assign bus.div_op2_o    = div_op2_q;
   assign bus.div_annul_o  = flush_i;
   assign state_o          = state_q;

`ifdef HILO_FWD_EN
   assign hi_o = hi_we ? hi_wdata : hi_q;
   assign lo_o = lo_we ? lo_wdata : lo_q;
`else
   assign hi_o = hi_q;
   assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_div_ctrl -- bench for hilo_div_ctrl: directed scenarios followed by
// randomized traffic, checked every cycle against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_hilo_div_ctrl;
   import hilo_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i, stall_i;
   logic [31:0] hi_o, lo_o;
   logic        stall_req_o;
   hilo_state_t state_o;

   always #5 clk = ~clk;

   hilo_div_ctrl_if bus();

   hilo_div_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .flush_i     (flush_i),
      .stall_i     (stall_i),
      .hi_o        (hi_o),
      .lo_o        (lo_o),
      .stall_req_o (stall_req_o),
      .state_o     (state_o)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [64:0] exp_q[$];  // {signed, op1, op2} of each expected launch

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // busy = a divide is outstanding, rel = result just retired
   bit          m_known = 0, m_busy = 0, m_rel = 0, m_start = 0, m_signed = 0;
   logic [31:0] m_op1 = '0, m_op2 = '0, m_hi = '0, m_lo = '0;

   function automatic logic [63:0] div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      int sa, sb, q, r;
      logic [31:0] qq, rr;
      if (b == 0) return 64'h0;
      if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
         sa = a; sb = b;
         q = sa / sb; r = sa % sb;
         qq = q; rr = r;
         return {rr, qq};
      end
      return {a % b, a / b};
   endfunction

   // ---------------- divider environment ----------------
   bit          d_active = 0;
   int          d_cnt = 0;
   int          d_lat = 3;
   logic [63:0] d_res;
   bit          force_ready = 0;
   logic [63:0] force_res = '0;
   bit          spurious_en = 0;

   task automatic env_divider();
      if (d_active && !bus.div_start_o) d_active = 0;
      if (!d_active && bus.div_start_o) begin
         d_active = 1;
         d_cnt    = d_lat;
         if (exp_q.size() > 0)
            chk("div_launch_ops", {bus.div_signed_o, bus.div_op1_o, bus.div_op2_o}, exp_q.pop_front());
         else
            chk("div_launch_unexpected", 65'd1, 65'd0);
         d_res = div_ref(bus.div_signed_o, bus.div_op1_o, bus.div_op2_o);
      end
      bus.div_ready_i  = 1'b0;
      bus.div_result_i = {$urandom, $urandom};
      if (d_active) begin
         if (d_cnt <= 1) begin
            bus.div_ready_i  = 1'b1;
            bus.div_result_i = d_res;
         end else begin
            d_cnt--;
         end
      end else if (spurious_en && $urandom_range(0, 15) == 0) begin
         bus.div_ready_i = 1'b1;
      end
      if (force_ready) begin
         bus.div_ready_i  = 1'b1;
         bus.div_result_i = force_res;
      end
   endtask

   task automatic model_eval();
      bit          req, idle, hw, lw;
      logic [31:0] nh, nl;
      hilo_state_t exp_st;
      req  = bus.ex_valid_i && is_div_op(bus.ex_op_i) && !flush_i;
      idle = !m_busy && !m_rel;
      hw = 0; lw = 0; nh = m_hi; nl = m_lo;
      if (rst && !flush_i) begin
         if (m_busy && bus.div_ready_i) begin
            hw = 1; lw = 1;
            nh = bus.div_result_i[63:32];
            nl = bus.div_result_i[31:0];
         end else if (idle && bus.ex_valid_i && !stall_i) begin
            if (bus.ex_op_i == OP_MTHI) begin hw = 1; nh = bus.ex_rs_i; end
            if (bus.ex_op_i == OP_MTLO) begin lw = 1; nl = bus.ex_rs_i; end
            if (bus.ex_op_i == OP_MULT || bus.ex_op_i == OP_MULTU) begin
               hw = 1; lw = 1;
               nh = bus.mul_res_i[63:32];
               nl = bus.mul_res_i[31:0];
            end
         end
      end
      if (m_known) begin
         exp_st = m_busy ? ST_WAIT : (m_rel ? ST_RELEASE : ST_IDLE);
         chk("stall_req", stall_req_o, m_busy || (idle && req));
         chk("div_annul", bus.div_annul_o, flush_i);
         chk("div_start", bus.div_start_o, m_start);
         chk("div_signed", bus.div_signed_o, m_signed);
         chk("div_op1", bus.div_op1_o, m_op1);
         chk("div_op2", bus.div_op2_o, m_op2);
         chk("state", state_o, exp_st);
`ifdef HILO_FWD_EN
         chk("hi_o", hi_o, hw ? nh : m_hi);
         chk("lo_o", lo_o, lw ? nl : m_lo);
`else
         chk("hi_o", hi_o, m_hi);
         chk("lo_o", lo_o, m_lo);
`endif
      end
      if (!rst) begin
         m_known = 1; m_busy = 0; m_rel = 0; m_start = 0; m_signed = 0;
         m_op1 = '0; m_op2 = '0; m_hi = '0; m_lo = '0;
      end else begin
         if (flush_i) begin
            m_busy = 0; m_rel = 0; m_start = 0;
         end else if (m_busy) begin
            if (bus.div_ready_i) begin m_busy = 0; m_rel = 1; m_start = 0; end
         end else if (m_rel) begin
            if (!stall_i) m_rel = 0;
         end else if (req) begin
            m_busy = 1; m_start = 1;
            m_signed = (bus.ex_op_i == OP_DIV);
            m_op1 = bus.ex_rs_i; m_op2 = bus.ex_rt_i;
            exp_q.push_back({m_signed, m_op1, m_op2});
         end
         if (hw) m_hi = nh;
         if (lw) m_lo = nl;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input bit v, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [63:0] mul,
                        input bit fl, input bit st);
      bus.ex_valid_i = v;
      bus.ex_op_i    = op;
      bus.ex_rs_i    = rs;
      bus.ex_rt_i    = rt;
      bus.mul_res_i  = mul;
      flush_i        = fl;
      stall_i        = st;
   endtask

   // One cycle: inputs already set at the negedge; ends at the next negedge.
   task automatic step();
      env_divider();
      #1;
      model_eval();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Run a divide already on the EX bus until the model retires it.
   task automatic run_div(input bit exp_signed, output int n_stall);
      int n;
      n = 0; n_stall = 0;
      while (!m_rel && n < 200) begin
         #1;
         if (stall_req_o) n_stall++;
         if (n == 1) begin
            chk("div_signed_lit", bus.div_signed_o, exp_signed);
            chk("div_start_lit", bus.div_start_o, 1'b1);
         end
         step();
         n++;
      end
      if (n >= 200) chk("div_timeout", 65'd0, 65'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ns;
      rst = 1'b0;
      drive(0, OP_NOP, 0, 0, 0, 0, 0);
      bus.div_ready_i  = 1'b0;
      bus.div_result_i = '0;

      // Reset state
      step(); step();
      rst = 1'b1;
      chk("rst_hi", hi_o, 32'h0);
      chk("rst_lo", lo_o, 32'h0);
      chk("rst_start", bus.div_start_o, 1'b0);
      chk("rst_state", state_o, ST_IDLE);
      chk("rst_op1", bus.div_op1_o, 32'h0);

      // Signed DIV -7 / 2, 34-cycle divider; DIV stays on the bus through RELEASE
      d_lat = 34;
      drive(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
      run_div(1'b1, ns);
      chk("div_stall_cycles", ns, 35);
      chk("div_hi_lit", hi_o, 32'hFFFF_FFFF);
      chk("div_lo_lit", lo_o, 32'hFFFF_FFFD);
      chk("release_state", state_o, ST_RELEASE);
      chk("release_start", bus.div_start_o, 1'b0);
      #1 chk("release_stall_req", stall_req_o, 1'b0);
      step();
      chk("after_release_state", state_o, ST_IDLE);
      chk("after_release_start", bus.div_start_o, 1'b0);
      drive(0, OP_NOP, 0, 0, 0, 0, 0);
      step();

      // DIVU by zero
      d_lat = 5;
      drive(1, OP_DIVU, 32'd100, 32'd0, 0, 0, 0);
      run_div(1'b0, ns);
      chk("divz_hi_lit", hi_o, 32'h0);
      chk("divz_lo_lit", lo_o, 32'h0);
      step();
      chk("divz_idle", state_o, ST_IDLE);
      drive(0, OP_NOP, 0, 0, 0, 0, 0);
      step();

      // MTHI then MTLO
      drive(1, OP_MTHI, 32'h1234_5678, 0, 0, 0, 0);
`ifdef HILO_FWD_EN
      #1 chk("mthi_fwd", hi_o, 32'h1234_5678);
`endif
      step();
      chk("mthi_lit", hi_o, 32'h1234_5678);
      drive(1, OP_MTLO, 32'h9ABC_DEF0, 0, 0, 0, 0);
`ifdef HILO_FWD_EN
      #1 chk("mtlo_fwd", lo_o, 32'h9ABC_DEF0);
`endif
      step();
      chk("mtlo_lit", lo_o, 32'h9ABC_DEF0);
      chk("mtlo_hi_kept", hi_o, 32'h1234_5678);

      // MULT held by a 3-cycle stall
      drive(1, OP_MULT, 0, 0, 64'h0000_0001_0000_0002, 0, 1);
      repeat (3) step();
      chk("mult_stall_hi", hi_o, 32'h1234_5678);
      chk("mult_stall_lo", lo_o, 32'h9ABC_DEF0);
      stall_i = 1'b0;
      step();
      chk("mult_hi_lit", hi_o, 32'h1);
      chk("mult_lo_lit", lo_o, 32'h2);
      drive(0, OP_NOP, 0, 0, 0, 0, 0);
      step();

      // Flush in WAIT coincident with div_ready_i
      d_lat = 50;
      drive(1, OP_DIV, 32'd1000, 32'd7, 0, 0, 0);
      repeat (4) step();
      chk("flush_pre_wait", state_o, ST_WAIT);
      flush_i     = 1'b1;
      force_ready = 1;
      force_res   = 64'hDEAD_BEEF_CAFE_F00D;
      #1 chk("flush_annul_lit", bus.div_annul_o, 1'b1);
      step();
      force_ready = 0;
      chk("flush_hi_kept", hi_o, 32'h1);
      chk("flush_lo_kept", lo_o, 32'h2);
      chk("flush_idle", state_o, ST_IDLE);
      chk("flush_start", bus.div_start_o, 1'b0);
      d_lat = 4;
      drive(1, OP_DIV, 32'd50, 32'd5, 0, 0, 0);
      step();
      chk("restart_state", state_o, ST_WAIT);
      chk("restart_start", bus.div_start_o, 1'b1);
      run_div(1'b1, ns);
      chk("restart_hi_lit", hi_o, 32'h0);
      chk("restart_lo_lit", lo_o, 32'd10);
      step();
      drive(0, OP_NOP, 0, 0, 0, 0, 0);
      step();

      // Reset while in WAIT
      drive(1, OP_MTHI, 32'hAAAA_AAAA, 0, 0, 0, 0);
      step();
      d_lat = 20;
      drive(1, OP_DIV, 32'd9, 32'd3, 0, 0, 0);
      repeat (3) step();
      chk("rstw_pre_state", state_o, ST_WAIT);
      chk("rstw_pre_hi", hi_o, 32'hAAAA_AAAA);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("rstw_hi", hi_o, 32'h0);
      chk("rstw_lo", lo_o, 32'h0);
      chk("rstw_start", bus.div_start_o, 1'b0);
      chk("rstw_state", state_o, ST_IDLE);
      drive(0, OP_NOP, 0, 0, 0, 0, 0);
      step();

      // Randomized traffic
      spurious_en = 1;
      for (int i = 0; i < 800; i++) begin
         logic [31:0] rs, rt;
         rs = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
         rt = ($urandom_range(0, 7) == 0) ? 32'h0 :
              (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom_range(1, 1000));
         d_lat = $urandom_range(1, 5);
         rst   = ($urandom_range(0, 63) != 0);
         drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rs, rt,
               {$urandom, $urandom}, $urandom_range(0, 15) == 0,
               $urandom_range(0, 3) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
